id_stage_pipe: RTL and testbench

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

---
 rtl/id_stage_pipe_if.sv | 39 +++
 rtl/id_stage_pipe.sv | 151 +++++++++++++++
 tb/tb_id_stage_pipe.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pipe_if.sv
// Bus bundle for id_stage_pipe: fetch offer, writeback port, flush,
// branch resolution and the registered ID/EX outputs.
interface id_stage_pipe_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      InValid;
  logic                      InReady;
  logic [31:0]               Instruction;
  logic [DATA_WIDTH-1:0]     PCResult;
  logic                      WbWriteEn;
  logic [REG_ADDR_WIDTH-1:0] WbWriteRegister;
  logic [DATA_WIDTH-1:0]     WbWriteData;
  logic                      FlushIn;
  logic                      BranchTaken;
  logic [DATA_WIDTH-1:0]     BranchAddress;
  logic                      OutValid;
  logic                      OutReady;
  logic [31:0]               OutInstruction;
  logic [DATA_WIDTH-1:0]     OutPC;
  logic [DATA_WIDTH-1:0]     OutReadData1;
  logic [DATA_WIDTH-1:0]     OutReadData2;
  logic [DATA_WIDTH-1:0]     OutImmExt;
  logic                      OutMemRead;

  modport master (
    output InValid, Instruction, PCResult, WbWriteEn, WbWriteRegister,
           WbWriteData, FlushIn, OutReady,
    input  InReady, BranchTaken, BranchAddress, OutValid, OutInstruction,
           OutPC, OutReadData1, OutReadData2, OutImmExt, OutMemRead
  );

  modport slave (
    input  InValid, Instruction, PCResult, WbWriteEn, WbWriteRegister,
           WbWriteData, FlushIn, OutReady,
    output InReady, BranchTaken, BranchAddress, OutValid, OutInstruction,
           OutPC, OutReadData1, OutReadData2, OutImmExt, OutMemRead
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Decode stage: register file, operand read, branch resolve, jal link write, ID/EX register.
// Optional macro ID_BYPASS_EN forwards same-cycle writeback data into operand reads.
module id_stage_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LINK_REG       = 31
) (
  input logic            Clk,
  input logic            Rst,
  id_stage_pipe_if.slave bus
);
  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] LINK_IDX = REG_ADDR_WIDTH'(LINK_REG);

  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LB   = 6'h20;
  localparam logic [5:0] OP_LH   = 6'h21;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_LBU  = 6'h24;
  localparam logic [5:0] OP_LHU  = 6'h25;

  logic [DATA_WIDTH-1:0]     regFile [NUM_REGS];
  logic                      linkPending;
  logic [DATA_WIDTH-1:0]     linkData;

  logic                      outValid;
  logic                      outMemRead;
  logic [31:0]               outInstruction;
  logic [DATA_WIDTH-1:0]     outPc;
  logic [DATA_WIDTH-1:0]     outReadData1;
  logic [DATA_WIDTH-1:0]     outReadData2;
  logic [DATA_WIDTH-1:0]     outImmExt;

  logic [5:0]                opcode;
  logic [REG_ADDR_WIDTH-1:0] rsIdx;
  logic [REG_ADDR_WIDTH-1:0] rtIdx;
  logic [REG_ADDR_WIDTH-1:0] exRtIdx;
  logic [DATA_WIDTH-1:0]     immSext;
  logic [DATA_WIDTH-1:0]     immExt;
  logic [DATA_WIDTH-1:0]     rsData;
  logic [DATA_WIDTH-1:0]     rtData;
  logic [DATA_WIDTH-1:0]     linkValue;
  logic                      isLoad;
  logic                      isJal;
  logic                      loadUse;
  logic                      inReady;
  logic                      accept;
  logic                      linkWrite;

  assign opcode  = bus.Instruction[31:26];
  assign rsIdx   = bus.Instruction[21 +: REG_ADDR_WIDTH];
  assign rtIdx   = bus.Instruction[16 +: REG_ADDR_WIDTH];
  assign exRtIdx = outInstruction[16 +: REG_ADDR_WIDTH];

  assign immSext = {{(DATA_WIDTH-16){bus.Instruction[15]}}, bus.Instruction[15:0]};
  assign immExt  = (opcode inside {OP_ANDI, OP_ORI, OP_XORI})
                 ? {{(DATA_WIDTH-16){1'b0}}, bus.Instruction[15:0]} : immSext;
  assign isLoad  = opcode inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  assign isJal   = (opcode == OP_JAL);

`ifdef ID_BYPASS_EN
  assign rsData = (rsIdx == '0) ? '0
                : (bus.WbWriteEn && bus.WbWriteRegister == rsIdx) ? bus.WbWriteData
                : regFile[rsIdx];
  assign rtData = (rtIdx == '0) ? '0
                : (bus.WbWriteEn && bus.WbWriteRegister == rtIdx) ? bus.WbWriteData
                : regFile[rtIdx];
`else
  assign rsData = (rsIdx == '0) ? '0 : regFile[rsIdx];
  assign rtData = (rtIdx == '0) ? '0 : regFile[rtIdx];
`endif

  // A load still sitting in ID/EX cannot feed its result to the instruction behind it.
  assign loadUse = bus.InValid && outValid && outMemRead && (exRtIdx != '0)
                && ((exRtIdx == rsIdx) || (exRtIdx == rtIdx));
  assign inReady = !Rst && !bus.FlushIn && !linkPending && !loadUse
                && (!outValid || bus.OutReady);
  assign accept  = bus.InValid && inReady;

  assign linkValue = bus.PCResult + DATA_WIDTH'(4);
  // The link write yields the port to writeback on the accept edge and retires one cycle later.
  assign linkWrite = (accept && isJal && !bus.WbWriteEn) || linkPending;

  assign bus.InReady       = inReady;
  assign bus.BranchTaken   = accept && (((opcode == OP_BEQ) && (rsData == rtData))
                                     || ((opcode == OP_BNE) && (rsData != rtData)));
  assign bus.BranchAddress = bus.PCResult + (immSext << 2);

  // NOTE: the register file is cleared by Rst so architectural state reads 0 afterwards;
  // a loop of non-blocking writes keeps it a plain flop array with no RAM macro semantics.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
    end else begin
      if (bus.WbWriteEn && bus.WbWriteRegister != '0)
        regFile[bus.WbWriteRegister] <= bus.WbWriteData;
      if (linkWrite && LINK_IDX != '0)
        regFile[LINK_IDX] <= linkPending ? linkData : linkValue;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      linkPending    <= 1'b0;
      linkData       <= '0;
      outValid       <= 1'b0;
      outMemRead     <= 1'b0;
      outInstruction <= '0;
      outPc          <= '0;
      outReadData1   <= '0;
      outReadData2   <= '0;
      outImmExt      <= '0;
    end else begin
      linkPending <= accept && isJal && bus.WbWriteEn;
      if (accept && isJal) linkData <= linkValue;

      if (bus.FlushIn) begin
        outValid       <= 1'b0;
        outMemRead     <= 1'b0;
        outInstruction <= '0;
        outPc          <= '0;
        outReadData1   <= '0;
        outReadData2   <= '0;
        outImmExt      <= '0;
      end else if (accept) begin
        outValid       <= 1'b1;
        outMemRead     <= isLoad;
        outInstruction <= bus.Instruction;
        outPc          <= bus.PCResult;
        outReadData1   <= rsData;
        outReadData2   <= rtData;
        outImmExt      <= immExt;
      end else if (bus.OutReady) begin
        outValid <= 1'b0;
      end
    end
  end

  assign bus.OutValid       = outValid;
  assign bus.OutMemRead     = outMemRead;
  assign bus.OutInstruction = outInstruction;
  assign bus.OutPC          = outPc;
  assign bus.OutReadData1   = outReadData1;
  assign bus.OutReadData2   = outReadData2;
  assign bus.OutImmExt      = outImmExt;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a vector table for single-cycle decode/handshake
// behaviour plus hand sequences for branch, jal link, hold, flush and mid-run reset.
module tb_id_stage_pipe;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef ID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] A   = 32'h0000_1234;
  localparam logic [31:0] B   = 32'hDEAD_BEEF;
  localparam logic [31:0] JAL = {6'h03, 26'h000_0010};

  logic Clk = 1'b0;
  logic Rst;
  int   checks   = 0;
  int   failures = 0;

  id_stage_pipe_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();
  id_stage_pipe #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .LINK_REG(31)) dut (
    .Clk(Clk), .Rst(Rst), .bus(bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        inValid;
    logic [31:0] instr;
    logic        wbEn;
    logic [4:0]  wbReg;
    logic [31:0] wbData;
    logic        outReady;
    logic        expInReady;
    logic        expOutValid;
    logic        chkData;
    logic [31:0] expInstr;
    logic [31:0] expRd1;
    logic [31:0] expRd2;
    logic [31:0] expImm;
    logic        expMemRead;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, 5'd0, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic vec_t mkVec(
    input logic iv, input logic [31:0] instr, input logic wbEn, input logic [4:0] wbReg,
    input logic [31:0] wbData, input logic oRdy, input logic eRdy, input logic eVal,
    input logic chk, input logic [31:0] eInstr, input logic [31:0] rd1,
    input logic [31:0] rd2, input logic [31:0] imm, input logic eMr);
    vec_t v;
    v.inValid = iv; v.instr = instr; v.wbEn = wbEn; v.wbReg = wbReg; v.wbData = wbData;
    v.outReady = oRdy; v.expInReady = eRdy; v.expOutValid = eVal; v.chkData = chk;
    v.expInstr = eInstr; v.expRd1 = rd1; v.expRd2 = rd2; v.expImm = imm; v.expMemRead = eMr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                       input logic wbEn, input logic [4:0] wbReg, input logic [31:0] wbData,
                       input logic oRdy, input logic flush);
    bus.InValid         = iv;
    bus.Instruction     = instr;
    bus.PCResult        = pc;
    bus.WbWriteEn       = wbEn;
    bus.WbWriteRegister = wbReg;
    bus.WbWriteData     = wbData;
    bus.OutReady        = oRdy;
    bus.FlushIn         = flush;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs.push_back(mkVec(1, rType(5, 0), 1, 5, A, 1, 1, 1, 1, rType(5, 0), BYP ? A : 32'h0, 0, 32'h20, 0));
    vecs.push_back(mkVec(1, rType(5, 6), 1, 6, B, 1, 1, 1, 1, rType(5, 6), A, BYP ? B : 32'h0, 32'h20, 0));
    vecs.push_back(mkVec(1, rType(6, 5), 0, 0, 0, 1, 1, 1, 1, rType(6, 5), B, A, 32'h20, 0));
    vecs.push_back(mkVec(1, iType(6'h0D, 6, 7, 16'h8001), 0, 0, 0, 1, 1, 1, 1, iType(6'h0D, 6, 7, 16'h8001), B, 0, 32'h0000_8001, 0));
    vecs.push_back(mkVec(1, iType(6'h08, 5, 7, 16'h8001), 0, 0, 0, 1, 1, 1, 1, iType(6'h08, 5, 7, 16'h8001), A, 0, 32'hFFFF_8001, 0));
    vecs.push_back(mkVec(1, iType(6'h23, 5, 8, 16'h0004), 0, 0, 0, 1, 1, 1, 1, iType(6'h23, 5, 8, 16'h0004), A, 0, 32'h4, 1));
    vecs.push_back(mkVec(1, rType(8, 8), 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(1, rType(8, 8), 0, 0, 0, 1, 1, 1, 1, rType(8, 8), 0, 0, 32'h20, 0));
    vecs.push_back(mkVec(1, iType(6'h20, 0, 0, 16'hFFFC), 0, 0, 0, 1, 1, 1, 1, iType(6'h20, 0, 0, 16'hFFFC), 0, 0, 32'hFFFF_FFFC, 1));
    vecs.push_back(mkVec(1, rType(0, 0), 0, 0, 0, 1, 1, 1, 1, rType(0, 0), 0, 0, 32'h20, 0));
    vecs.push_back(mkVec(1, iType(6'h0C, 6, 9, 16'hFFFF), 0, 0, 0, 1, 1, 1, 1, iType(6'h0C, 6, 9, 16'hFFFF), B, 0, 32'h0000_FFFF, 0));
    vecs.push_back(mkVec(1, iType(6'h0E, 5, 9, 16'h8000), 0, 0, 0, 1, 1, 1, 1, iType(6'h0E, 5, 9, 16'h8000), A, 0, 32'h0000_8000, 0));
    vecs.push_back(mkVec(1, iType(6'h25, 6, 10, 16'h0000), 0, 0, 0, 1, 1, 1, 1, iType(6'h25, 6, 10, 16'h0000), B, 0, 32'h0, 1));
    vecs.push_back(mkVec(0, rType(10, 10), 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(1, iType(6'h23, 0, 11, 16'h0010), 0, 0, 0, 1, 1, 1, 1, iType(6'h23, 0, 11, 16'h0010), 0, 0, 32'h10, 1));
    vecs.push_back(mkVec(1, rType(11, 0), 0, 0, 0, 0, 0, 1, 1, iType(6'h23, 0, 11, 16'h0010), 0, 0, 32'h10, 1));
    vecs.push_back(mkVec(1, rType(11, 0), 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(1, rType(11, 0), 0, 0, 0, 1, 1, 1, 1, rType(11, 0), 0, 0, 32'h20, 0));
    vecs.push_back(mkVec(1, rType(0, 5), 1, 0, 32'hAAAA, 1, 1, 1, 1, rType(0, 5), 0, A, 32'h20, 0));
    vecs.push_back(mkVec(1, rType(0, 6), 0, 0, 0, 1, 1, 1, 1, rType(0, 6), 0, B, 32'h20, 0));
    vecs.push_back(mkVec(1, iType(6'h21, 5, 12, 16'h7FFF), 0, 0, 0, 1, 1, 1, 1, iType(6'h21, 5, 12, 16'h7FFF), A, 0, 32'h0000_7FFF, 1));
    vecs.push_back(mkVec(1, iType(6'h24, 6, 0, 16'h8000), 0, 0, 0, 1, 1, 1, 1, iType(6'h24, 6, 0, 16'h8000), B, 0, 32'hFFFF_8000, 1));
    vecs.push_back(mkVec(1, iType(6'h2B, 0, 0, 16'h0000), 0, 0, 0, 1, 1, 1, 1, iType(6'h2B, 0, 0, 16'h0000), 0, 0, 32'h0, 0));

    // Reset state, with a taken-looking beq offered throughout
    Rst = 1'b1;
    drive(1, iType(6'h04, 0, 0, 16'h0001), 32'h10, 0, 0, 0, 1, 0);
    tick();
    check("rst InReady", bus.InReady, 0);
    check("rst BranchTaken", bus.BranchTaken, 0);
    check("rst OutValid", bus.OutValid, 0);
    check("rst OutInstruction", bus.OutInstruction, 0);
    check("rst OutReadData1", bus.OutReadData1, 0);
    Rst = 1'b0;

    for (int r = 1; r < 32; r++) begin
      drive(1, rType(5'(r), 5'(32 - r)), 32'(r * 4), 0, 0, 0, 1, 0);
      #1;
      check($sformatf("clr r%0d InReady", r), bus.InReady, 1);
      tick();
      check($sformatf("clr r%0d OutValid", r), bus.OutValid, 1);
      check($sformatf("clr r%0d rd1", r), bus.OutReadData1, 0);
      check($sformatf("clr r%0d rd2", r), bus.OutReadData2, 0);
      check($sformatf("clr r%0d OutPC", r), bus.OutPC, 32'(r * 4));
    end

    foreach (vecs[i]) begin
      drive(vecs[i].inValid, vecs[i].instr, 32'h1000, vecs[i].wbEn, vecs[i].wbReg,
            vecs[i].wbData, vecs[i].outReady, 0);
      #1;
      check($sformatf("v%0d InReady", i), bus.InReady, vecs[i].expInReady);
      tick();
      check($sformatf("v%0d OutValid", i), bus.OutValid, vecs[i].expOutValid);
      if (vecs[i].chkData) begin
        check($sformatf("v%0d OutInstruction", i), bus.OutInstruction, vecs[i].expInstr);
        check($sformatf("v%0d rd1", i), bus.OutReadData1, vecs[i].expRd1);
        check($sformatf("v%0d rd2", i), bus.OutReadData2, vecs[i].expRd2);
        check($sformatf("v%0d imm", i), bus.OutImmExt, vecs[i].expImm);
        check($sformatf("v%0d OutMemRead", i), bus.OutMemRead, vecs[i].expMemRead);
      end
    end

    // Branch resolution and target
    drive(1, iType(6'h04, 1, 1, 16'hFFFF), 32'h100, 0, 0, 0, 1, 0);
    #1;
    check("beq taken", bus.BranchTaken, 1);
    check("beq address", bus.BranchAddress, 32'h0000_00FC);
    tick();
    check("beq OutPC", bus.OutPC, 32'h100);
    drive(1, iType(6'h05, 5, 6, 16'h0003), 32'h200, 0, 0, 0, 1, 0);
    #1;
    check("bne taken", bus.BranchTaken, 1);
    check("bne address", bus.BranchAddress, 32'h0000_020C);
    tick();
    drive(1, iType(6'h05, 1, 1, 16'h0003), 32'h200, 0, 0, 0, 1, 0);
    #1;
    check("bne equal not taken", bus.BranchTaken, 0);
    tick();
    drive(1, iType(6'h04, 5, 6, 16'h0003), 32'h200, 0, 0, 0, 1, 0);
    #1;
    check("beq unequal not taken", bus.BranchTaken, 0);
    tick();
    drive(1, iType(6'h04, 0, 0, 16'h0001), 32'h300, 0, 0, 0, 1, 1);
    #1;
    check("flush beq not taken", bus.BranchTaken, 0);
    check("flush InReady", bus.InReady, 0);
    tick();
    check("flush OutValid", bus.OutValid, 0);

    // jal colliding with a writeback: link write deferred one cycle
    drive(1, JAL, 32'h40, 1, 12, 32'h55, 1, 0);
    #1;
    check("jal InReady", bus.InReady, 1);
    tick();
    check("jal OutValid", bus.OutValid, 1);
    check("jal OutInstruction", bus.OutInstruction, JAL);
    drive(1, rType(31, 12), 32'h44, 0, 0, 0, 1, 0);
    #1;
    check("jal pending InReady", bus.InReady, 0);
    tick();
    check("jal pending OutValid", bus.OutValid, 0);
    check("jal after pending InReady", bus.InReady, 1);
    tick();
    check("jal link r31", bus.OutReadData1, 32'h44);
    check("jal wb r12", bus.OutReadData2, 32'h55);

    // jal without writeback: link written on the accept edge, no stall
    drive(1, JAL, 32'h80, 0, 0, 0, 1, 0);
    tick();
    drive(1, rType(31, 0), 32'h84, 0, 0, 0, 1, 0);
    #1;
    check("jal direct InReady", bus.InReady, 1);
    tick();
    check("jal direct r31", bus.OutReadData1, 32'h84);

    // Hold for three cycles, then flush while stalled
    drive(1, iType(6'h08, 5, 6, 16'h1234), 32'h300, 0, 0, 0, 1, 0);
    tick();
    drive(1, rType(1, 2), 32'h304, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("hold%0d InReady", c), bus.InReady, 0);
      tick();
      check($sformatf("hold%0d OutValid", c), bus.OutValid, 1);
      check($sformatf("hold%0d OutInstruction", c), bus.OutInstruction, iType(6'h08, 5, 6, 16'h1234));
      check($sformatf("hold%0d OutPC", c), bus.OutPC, 32'h300);
      check($sformatf("hold%0d rd1", c), bus.OutReadData1, A);
      check($sformatf("hold%0d rd2", c), bus.OutReadData2, B);
      check($sformatf("hold%0d imm", c), bus.OutImmExt, 32'h1234);
    end
    drive(1, rType(1, 2), 32'h304, 0, 0, 0, 0, 1);
    #1;
    check("hold flush InReady", bus.InReady, 0);
    tick();
    check("hold flush OutValid", bus.OutValid, 0);

    // Flush during a pending link write: the link still lands
    drive(1, JAL, 32'h200, 1, 13, 32'h77, 1, 0);
    tick();
    check("jal2 OutValid", bus.OutValid, 1);
    drive(1, rType(31, 13), 32'h204, 0, 0, 0, 1, 1);
    #1;
    check("jal2 flush InReady", bus.InReady, 0);
    tick();
    check("jal2 flush OutValid", bus.OutValid, 0);
    drive(1, rType(31, 13), 32'h204, 0, 0, 0, 1, 0);
    #1;
    check("jal2 read InReady", bus.InReady, 1);
    tick();
    check("jal2 link r31", bus.OutReadData1, 32'h204);
    check("jal2 wb r13", bus.OutReadData2, 32'h77);

    // Reset mid-operation with a link write pending
    drive(1, JAL, 32'h500, 1, 14, 32'h99, 1, 0);
    tick();
    check("mid jal OutValid", bus.OutValid, 1);
    Rst = 1'b1;
    drive(1, iType(6'h04, 0, 0, 16'h0001), 32'h504, 0, 0, 0, 1, 0);
    #1;
    check("mid rst InReady", bus.InReady, 0);
    check("mid rst BranchTaken", bus.BranchTaken, 0);
    tick();
    Rst = 1'b0;
    check("mid rst OutValid", bus.OutValid, 0);
    check("mid rst OutInstruction", bus.OutInstruction, 0);
    check("mid rst OutPC", bus.OutPC, 0);
    check("mid rst OutMemRead", bus.OutMemRead, 0);
    drive(1, rType(14, 31), 32'h600, 0, 0, 0, 1, 0);
    #1;
    check("post rst InReady", bus.InReady, 1);
    tick();
    check("post rst OutValid", bus.OutValid, 1);
    check("post rst r14", bus.OutReadData1, 0);
    check("post rst r31", bus.OutReadData2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
